ber_log_capture: RTL and testbench

Capture buffer between the DSP datapath and the register file. When the register file issues a run-log command, the block records consecutive DSP samples into an internal single-port-write / single-port-read RAM until the RAM is full, then flags `o_mem_full`. The register file later reads the captured samples back by address, under `i_read_log`, for transfer to the MicroBlaze over GPIO.

---
 rtl/ber_log_capture.sv | 99 +++++++++
 tb/tb_ber_log_capture.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ber_log_capture.sv
// DSP sample capture RAM: a run-log edge fills the RAM once, and the
// register file reads the samples back by address with a registered port.
module ber_log_capture #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 15
) (
  input  logic               clk,
  input  logic               i_rstn,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_run_log,
  input  logic               i_read_log,
  input  logic [NB_ADDR-1:0] i_addr_log,
  output logic [NB_DATA-1:0] o_data_log,
  output logic               o_mem_full,
  output logic               o_logging
);

  localparam int DEPTH = 1 << NB_ADDR;

  typedef enum logic {
    IDLE,
    CAPTURE
  } state_e;

  state_e               state_q, state_d;
  logic [NB_ADDR-1:0]   wr_ptr_q, wr_ptr_d;
  logic                 full_q, full_d;
  logic                 run_q;
  logic                 start;
  logic                 we;
  logic [NB_DATA-1:0]   rd_q;

  logic [NB_DATA-1:0]   mem [DEPTH];

  assign start = i_run_log & ~run_q;

  always_ff @(posedge clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      full_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
      run_q    <= i_run_log;
    end
  end

  // A start edge wins over any strobe on the same cycle.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    full_d   = full_q;
    we       = 1'b0;
    if (start) begin
      state_d  = CAPTURE;
      wr_ptr_d = '0;
      full_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        CAPTURE: begin
          if (i_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == {NB_ADDR{1'b1}}) begin
              state_d = IDLE;
              full_d  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr_q] <= i_data;
    end
  end

  // Non-blocking read alongside the write gives read-first behaviour.
  always_ff @(posedge clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_q <= '0;
    end else if (i_read_log) begin
      rd_q <= mem[i_addr_log];
    end
  end

  assign o_data_log = rd_q;
  assign o_mem_full = full_q;
  assign o_logging  = (state_q == CAPTURE);

endmodule

// File: tb/tb_ber_log_capture.sv
// Directed bench for ber_log_capture with a 16-entry RAM.
// Inputs change on the falling edge; outputs are sampled 1ns after rising.
module tb_ber_log_capture;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 4;
  localparam int DEPTH   = 16;

  logic               clk;
  logic               i_rstn;
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               i_run_log;
  logic               i_read_log;
  logic [NB_ADDR-1:0] i_addr_log;
  logic [NB_DATA-1:0] o_data_log;
  logic               o_mem_full;
  logic               o_logging;

  int n_cmp = 0;
  int n_err = 0;

  ber_log_capture #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR)
  ) dut (
    .clk       (clk),
    .i_rstn    (i_rstn),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_run_log (i_run_log),
    .i_read_log(i_read_log),
    .i_addr_log(i_addr_log),
    .o_data_log(o_data_log),
    .o_mem_full(o_mem_full),
    .o_logging (o_logging)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cap(input logic vv, input logic [31:0] vd);
    @(negedge clk);
    i_run_log = 1'b0;
    i_valid   = 1'b0;
    @(negedge clk);
    i_run_log = 1'b1;
    i_valid   = vv;
    i_data    = vd;
    step();
    chk("start_logging", {31'd0, o_logging}, 32'd1);
    chk("start_full", {31'd0, o_mem_full}, 32'd0);
  endtask

  task automatic write_seq(input logic [31:0] base, input int cnt,
                           input int last);
    for (int n = 0; n < cnt; n++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = base + n;
      step();
      chk("wr_logging", {31'd0, o_logging}, (n == last) ? 32'd0 : 32'd1);
      chk("wr_full", {31'd0, o_mem_full}, (n == last) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic read_all(input logic [31:0] base);
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      i_read_log = 1'b1;
      i_addr_log = a[NB_ADDR-1:0];
      step();
      chk("read", o_data_log, base + a);
    end
    i_read_log = 1'b0;
  endtask

  initial begin
    i_rstn     = 1'b0;
    i_data     = '0;
    i_valid    = 1'b0;
    i_run_log  = 1'b0;
    i_read_log = 1'b0;
    i_addr_log = '0;
    #1;
    chk("rst_logging", {31'd0, o_logging}, 32'd0);
    chk("rst_full", {31'd0, o_mem_full}, 32'd0);
    chk("rst_data", o_data_log, 32'd0);
    @(negedge clk);
    i_rstn = 1'b1;
    step();
    chk("idle_logging", {31'd0, o_logging}, 32'd0);

    // basic continuous capture
    start_cap(1'b0, 32'd0);
    write_seq(32'h100, DEPTH, DEPTH - 1);
    read_all(32'h100);

    // run held high: no retrigger, strobes ignored
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = 32'hDEAD_0000 + c;
      step();
      chk("hold_full", {31'd0, o_mem_full}, 32'd1);
      chk("hold_logging", {31'd0, o_logging}, 32'd0);
    end
    @(negedge clk);
    i_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      i_addr_log = a[NB_ADDR-1:0];
      step();
      chk("read_hold", o_data_log, 32'h10F);
    end
    read_all(32'h100);

    // sparse strobes: one valid every 4th cycle
    start_cap(1'b0, 32'd0);
    begin
      int k;
      k = 0;
      for (int c = 0; c < 4 * DEPTH; c++) begin
        @(negedge clk);
        i_valid = (c % 4 == 3);
        i_data  = 32'h300 + k;
        step();
        if (c % 4 == 3) begin
          k++;
          chk("sparse_full", {31'd0, o_mem_full},
              (k == DEPTH) ? 32'd1 : 32'd0);
          chk("sparse_logging", {31'd0, o_logging},
              (k == DEPTH) ? 32'd0 : 32'd1);
        end
      end
      @(negedge clk);
      i_valid = 1'b0;
    end
    read_all(32'h300);

    // restart after 5 writes; strobe on the start cycle is dropped
    start_cap(1'b0, 32'd0);
    write_seq(32'h400, 5, -1);
    start_cap(1'b1, 32'h0BAD);
    // same-cycle read of the address being written returns old data
    @(negedge clk);
    i_valid    = 1'b1;
    i_data     = 32'h200;
    i_read_log = 1'b1;
    i_addr_log = '0;
    step();
    chk("read_first", o_data_log, 32'h400);
    chk("rs_logging", {31'd0, o_logging}, 32'd1);
    i_read_log = 1'b0;
    write_seq(32'h201, DEPTH - 1, DEPTH - 2);
    read_all(32'h200);

    // reset in the middle of a capture
    start_cap(1'b0, 32'd0);
    write_seq(32'h500, 7, -1);
    @(negedge clk);
    #2;
    i_rstn    = 1'b0;
    i_run_log = 1'b0;
    #1;
    chk("arst_logging", {31'd0, o_logging}, 32'd0);
    chk("arst_full", {31'd0, o_mem_full}, 32'd0);
    chk("arst_data", o_data_log, 32'd0);
    @(negedge clk);
    i_rstn = 1'b1;
    start_cap(1'b0, 32'd0);
    write_seq(32'h600, DEPTH, DEPTH - 1);
    read_all(32'h600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
